adxl345_sequencer: RTL



---
 rtl/adxl345_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/adxl345_sequencer.sv
// rtl/adxl345_sequencer.sv - ADXL345 bring-up and periodic X/Y/Z sample sequencer over a byte SPI engine
module adxl345_sequencer #(
    parameter int         SAMPLE_DIV = 500000,
    parameter int         PWRUP_WAIT = 100000,
    parameter int         CS_GAP     = 4,
    parameter int         TIMEOUT    = 4096,
    parameter logic [7:0] FMT_VAL    = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_busy,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    output logic        cs_n,
    output logic [15:0] X,
    output logic [15:0] Y,
    output logic [15:0] Z,
    output logic        data_valid,
    output logic        init_done,
    output logic        id_err,
    output logic        overrun
);
    localparam int WAIT_W = $clog2(PWRUP_WAIT + 1);
    localparam int TICK_W = $clog2(SAMPLE_DIV + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = $clog2(CS_GAP + 1);

    typedef enum logic [3:0] {
        S_PWRUP, S_ID, S_ID_CHK, S_FMT, S_PWR, S_IDLE, S_READ, S_UPDATE, S_GAP
    } state_t;

    state_t            state, gap_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [2:0]        byte_idx;
    logic              outstanding, launch, pending;
    logic [7:0]        id_byte;
    logic [7:0]        shadow [0:5];
    logic              tick, consume;
    logic [2:0]        last_idx;

    function automatic logic [7:0] tx_byte(input state_t s, input logic [2:0] idx);
        logic first;
        first = (idx == 3'd0);
        case (s)
            S_ID:    tx_byte = first ? 8'h80 : 8'h00;
            S_FMT:   tx_byte = first ? 8'h31 : FMT_VAL;
            S_PWR:   tx_byte = first ? 8'h2D : 8'h08;
            S_READ:  tx_byte = first ? 8'hF2 : 8'h00;
            default: tx_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        tick     = init_done && (tick_cnt == TICK_W'(SAMPLE_DIV - 1));
        consume  = (state == S_IDLE) && pending;
        last_idx = (state == S_READ) ? 3'd6 : 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_PWRUP;
            gap_next    <= S_IDLE;
            wait_cnt    <= '0;
            tick_cnt    <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
            byte_idx    <= '0;
            outstanding <= 1'b0;
            launch      <= 1'b0;
            pending     <= 1'b0;
            id_byte     <= '0;
            for (int i = 0; i < 6; i++) shadow[i] <= '0;
            cs_n        <= 1'b1;
            spi_start   <= 1'b0;
            spi_tx      <= '0;
            X           <= '0;
            Y           <= '0;
            Z           <= '0;
            data_valid  <= 1'b0;
            init_done   <= 1'b0;
            id_err      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            spi_start  <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;

            if (!init_done)  tick_cnt <= '0;
            else if (tick)   tick_cnt <= '0;
            else             tick_cnt <= tick_cnt + 1'b1;

            // One-deep request queue: a tick that finds it full is dropped and reported.
            if (tick) begin
                if (pending && !consume) overrun <= 1'b1;
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end

            case (state)
                S_PWRUP: begin
                    if (wait_cnt == WAIT_W'(PWRUP_WAIT - 1)) begin
                        state    <= S_ID;
                        cs_n     <= 1'b0;
                        byte_idx <= '0;
                        launch   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ID, S_FMT, S_PWR, S_READ: begin
                    if (outstanding) begin
                        if (spi_done) begin
                            if (state == S_ID && byte_idx == 3'd1) id_byte <= spi_rx;
                            if (state == S_READ && byte_idx != 3'd0) shadow[byte_idx - 3'd1] <= spi_rx;
                            if (byte_idx == last_idx) begin
                                outstanding <= 1'b0;
                                cs_n        <= 1'b1;
                                gap_cnt     <= '0;
                                case (state)
                                    S_ID:    begin state <= S_GAP; gap_next <= S_ID_CHK; end
                                    S_FMT:   begin state <= S_GAP; gap_next <= S_PWR; end
                                    S_PWR:   begin state <= S_GAP; gap_next <= S_IDLE; end
                                    default: state <= S_UPDATE;
                                endcase
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                                tmo_cnt  <= '0;
                                if (!spi_busy) begin
                                    spi_start <= 1'b1;
                                    spi_tx    <= tx_byte(state, byte_idx + 3'd1);
                                end else begin
                                    outstanding <= 1'b0;
                                    launch      <= 1'b1;
                                end
                            end
                        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                            // Engine hung: drop the device and rerun bring-up; X/Y/Z keep old data.
                            outstanding <= 1'b0;
                            cs_n        <= 1'b1;
                            init_done   <= 1'b0;
                            pending     <= 1'b0;
                            wait_cnt    <= '0;
                            state       <= S_PWRUP;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end else if (launch && !spi_busy) begin
                        spi_start   <= 1'b1;
                        spi_tx      <= tx_byte(state, byte_idx);
                        outstanding <= 1'b1;
                        launch      <= 1'b0;
                        tmo_cnt     <= '0;
                    end
                end
                S_ID_CHK: begin
                    if (id_byte == 8'hE5) begin
                        id_err   <= 1'b0;
                        state    <= S_FMT;
                        cs_n     <= 1'b0;
                        byte_idx <= '0;
                        launch   <= 1'b1;
                    end else begin
                        id_err   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_PWRUP;
                    end
                end
                S_IDLE: begin
                    if (pending) begin
                        state    <= S_READ;
                        cs_n     <= 1'b0;
                        byte_idx <= '0;
                        launch   <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    X          <= {shadow[1], shadow[0]};
                    Y          <= {shadow[3], shadow[2]};
                    Z          <= {shadow[5], shadow[4]};
                    data_valid <= 1'b1;
                    gap_cnt    <= '0;
                    gap_next   <= S_IDLE;
                    state      <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                        state <= gap_next;
                        if (gap_next == S_PWR) begin
                            cs_n     <= 1'b0;
                            byte_idx <= '0;
                            launch   <= 1'b1;
                        end
                        if (gap_next == S_IDLE) init_done <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end
endmodule
